// File: rtl/can_frame_receiver.sv
// CAN receiver: de-stuffs, parses and CRC-checks standard 11-bit ID
// data/remote frames, drives ACK, and pulses per-frame status.
`timescale 1ns/1ps
module can_frame_receiver #(
    parameter int IDLE_BITS         = 11,
    parameter int INTERMISSION_BITS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bit_en,
    input  logic        rx_bus,
    output logic        ack_drive,
    output logic [10:0] rx_id,
    output logic        rx_rtr,
    output logic [3:0]  rx_dlc,
    output logic [63:0] rx_data,
    output logic        rx_valid,
    output logic        stuff_err,
    output logic        crc_err,
    output logic        form_err
);

    typedef enum logic [3:0] {
        S_WAIT_IDLE, S_IDLE, S_ID, S_CTRL, S_DATA, S_CRC,
        S_CRC_DELIM, S_ACK_SLOT, S_ACK_DELIM, S_EOF, S_INTERM
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [2:0]  run_q, run_d;
    logic        last_q, last_d;
    logic [14:0] crc_q, crc_d;
    logic [14:0] rxcrc_q, rxcrc_d;
    logic [6:0]  nbits_q, nbits_d;
    logic [10:0] id_q, id_d;
    logic        rtr_q, rtr_d;
    logic [3:0]  dlc_q, dlc_d;
    logic [63:0] data_q, data_d;
    logic        ack_q, ack_d;
    logic        valid_q, valid_d;
    logic        serr_q, serr_d;
    logic        cerr_q, cerr_d;
    logic        ferr_q, ferr_d;

    logic        zone, stuff;
    logic [3:0]  dlc_full, nbytes;
    logic [5:0]  didx;

    function automatic logic [14:0] crc_next(input logic [14:0] c,
                                             input logic b);
        logic fb;
        fb = b ^ c[14];
        return {c[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
    endfunction

    // Next-state, de-stuffing, field capture and status pulses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        last_d  = last_q;
        crc_d   = crc_q;
        rxcrc_d = rxcrc_q;
        nbits_d = nbits_q;
        id_d    = id_q;
        rtr_d   = rtr_q;
        dlc_d   = dlc_q;
        data_d  = data_q;
        ack_d   = ack_q;
        valid_d = 1'b0;
        serr_d  = 1'b0;
        cerr_d  = 1'b0;
        ferr_d  = 1'b0;
        zone    = 1'b0;
        stuff   = 1'b0;
        dlc_full = {dlc_q[2:0], rx_bus};
        nbytes  = rtr_q ? 4'd0 : (dlc_full[3] ? 4'd8 : dlc_full);
        didx    = 6'd63 - cnt_q[5:0];
        if (bit_en) begin
            zone = (state_q inside {S_ID, S_CTRL, S_DATA, S_CRC}) ||
                   (state_q == S_CRC_DELIM && run_q == 3'd5);
            stuff = zone && (run_q == 3'd5);
            if (zone) begin
                if (stuff) begin
                    run_d  = 3'd1;
                    last_d = rx_bus;
                    if (rx_bus == last_q) begin
                        serr_d  = 1'b1;
                        state_d = S_WAIT_IDLE;
                        cnt_d   = 7'd0;
                    end
                end else begin
                    run_d  = (rx_bus == last_q) ? run_q + 3'd1 : 3'd1;
                    last_d = rx_bus;
                end
            end
            if (!stuff) begin
                unique case (state_q)
                    S_WAIT_IDLE: begin
                        if (!rx_bus) begin
                            cnt_d = 7'd0;
                        end else if (cnt_q == 7'(IDLE_BITS - 1)) begin
                            cnt_d   = 7'd0;
                            state_d = S_IDLE;
                        end else begin
                            cnt_d = cnt_q + 7'd1;
                        end
                    end
                    S_IDLE: begin
                        if (!rx_bus) begin
                            crc_d   = crc_next(15'd0, 1'b0);
                            run_d   = 3'd1;
                            last_d  = 1'b0;
                            data_d  = 64'd0;
                            cnt_d   = 7'd0;
                            state_d = S_ID;
                        end
                    end
                    S_ID: begin
                        crc_d = crc_next(crc_q, rx_bus);
                        id_d  = {id_q[9:0], rx_bus};
                        if (cnt_q == 7'd10) begin
                            cnt_d   = 7'd0;
                            state_d = S_CTRL;
                        end else begin
                            cnt_d = cnt_q + 7'd1;
                        end
                    end
                    S_CTRL: begin
                        crc_d = crc_next(crc_q, rx_bus);
                        cnt_d = cnt_q + 7'd1;
                        if (cnt_q == 7'd0) rtr_d = rx_bus;
                        if (cnt_q >= 7'd3) dlc_d = dlc_full;
                        if (cnt_q == 7'd1 && rx_bus) begin
                            ferr_d  = 1'b1;
                            cnt_d   = 7'd0;
                            state_d = S_WAIT_IDLE;
                        end else if (cnt_q == 7'd6) begin
                            cnt_d   = 7'd0;
                            nbits_d = {nbytes, 3'b000};
                            state_d = (nbytes == 4'd0) ? S_CRC : S_DATA;
                        end
                    end
                    S_DATA: begin
                        crc_d        = crc_next(crc_q, rx_bus);
                        data_d[didx] = rx_bus;
                        if (cnt_q == nbits_q - 7'd1) begin
                            cnt_d   = 7'd0;
                            state_d = S_CRC;
                        end else begin
                            cnt_d = cnt_q + 7'd1;
                        end
                    end
                    S_CRC: begin
                        rxcrc_d = {rxcrc_q[13:0], rx_bus};
                        if (cnt_q == 7'd14) begin
                            cnt_d   = 7'd0;
                            state_d = S_CRC_DELIM;
                        end else begin
                            cnt_d = cnt_q + 7'd1;
                        end
                    end
                    S_CRC_DELIM: begin
                        cnt_d = 7'd0;
                        if (!rx_bus) begin
                            ferr_d  = 1'b1;
                            state_d = S_WAIT_IDLE;
                        end else if (rxcrc_q != crc_q) begin
                            cerr_d  = 1'b1;
                            state_d = S_WAIT_IDLE;
                        end else begin
                            ack_d   = 1'b1;
                            state_d = S_ACK_SLOT;
                        end
                    end
                    S_ACK_SLOT: begin
                        ack_d   = 1'b0;
                        state_d = S_ACK_DELIM;
                    end
                    S_ACK_DELIM: begin
                        cnt_d = 7'd0;
                        if (!rx_bus) begin
                            ferr_d  = 1'b1;
                            state_d = S_WAIT_IDLE;
                        end else begin
                            state_d = S_EOF;
                        end
                    end
                    S_EOF: begin
                        if (!rx_bus) begin
                            ferr_d  = 1'b1;
                            cnt_d   = 7'd0;
                            state_d = S_WAIT_IDLE;
                        end else if (cnt_q == 7'd6) begin
                            valid_d = 1'b1;
                            cnt_d   = 7'd0;
                            state_d = S_INTERM;
                        end else begin
                            cnt_d = cnt_q + 7'd1;
                        end
                    end
                    S_INTERM: begin
                        if (!rx_bus) begin
                            ferr_d  = 1'b1;
                            cnt_d   = 7'd0;
                            state_d = S_WAIT_IDLE;
                        end else if (cnt_q == 7'(INTERMISSION_BITS - 1)) begin
                            cnt_d   = 7'd0;
                            state_d = S_IDLE;
                        end else begin
                            cnt_d = cnt_q + 7'd1;
                        end
                    end
                    default: begin
                        cnt_d   = 7'd0;
                        state_d = S_WAIT_IDLE;
                    end
                endcase
            end
        end
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT_IDLE;
            cnt_q   <= 7'd0;
            run_q   <= 3'd0;
            last_q  <= 1'b0;
            crc_q   <= 15'd0;
            rxcrc_q <= 15'd0;
            nbits_q <= 7'd0;
            id_q    <= 11'd0;
            rtr_q   <= 1'b0;
            dlc_q   <= 4'd0;
            data_q  <= 64'd0;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            serr_q  <= 1'b0;
            cerr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            last_q  <= last_d;
            crc_q   <= crc_d;
            rxcrc_q <= rxcrc_d;
            nbits_q <= nbits_d;
            id_q    <= id_d;
            rtr_q   <= rtr_d;
            dlc_q   <= dlc_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            serr_q  <= serr_d;
            cerr_q  <= cerr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign ack_drive = ack_q;
    assign rx_id     = id_q;
    assign rx_rtr    = rtr_q;
    assign rx_dlc    = dlc_q;
    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign stuff_err = serr_q;
    assign crc_err   = cerr_q;
    assign form_err  = ferr_q;

endmodule

// File: tb/tb_can_frame_receiver.sv
// Bench for can_frame_receiver: builds stuffed frames from a bit-level
// model and scoreboards every status pulse against its expected bit slot.
`timescale 1ns/1ps
module tb_can_frame_receiver;

    localparam int K_VALID = 0;
    localparam int K_STUFF = 1;
    localparam int K_CRC   = 2;
    localparam int K_FORM  = 3;

    logic        clk;
    logic        rst_n;
    logic        bit_en;
    logic        rx_bus;
    logic        ack_drive;
    logic [10:0] rx_id;
    logic        rx_rtr;
    logic [3:0]  rx_dlc;
    logic [63:0] rx_data;
    logic        rx_valid;
    logic        stuff_err;
    logic        crc_err;
    logic        form_err;

    can_frame_receiver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_en    (bit_en),
        .rx_bus    (rx_bus),
        .ack_drive (ack_drive),
        .rx_id     (rx_id),
        .rx_rtr    (rx_rtr),
        .rx_dlc    (rx_dlc),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .stuff_err (stuff_err),
        .crc_err   (crc_err),
        .form_err  (form_err)
    );

    typedef struct {
        int          kind;
        int          at;
        logic [10:0] id;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    bit   tx[$];
    int   stuff_pos[$];
    int   raw_pos[$];
    int   crc_end, ack_idx, eof_idx;
    int   cur_bit;
    int   ack_cnt, ack_at;
    int   n_tests, n_fail;
    int   mon_kind;
    exp_t mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] crc_step(input logic [14:0] c,
                                             input bit b);
        logic [14:0] n;
        n = {c[13:0], 1'b0};
        if (b != c[14]) n = n ^ 15'h4599;
        return n;
    endfunction

    function automatic int payload_bytes(input logic rtr, input logic [3:0] dlc);
        if (rtr) return 0;
        if (dlc > 4'd8) return 8;
        return int'(dlc);
    endfunction

    function automatic logic [63:0] exp_payload(input logic rtr,
                                                input logic [3:0] dlc,
                                                input logic [63:0] data);
        int nb;
        nb = payload_bytes(rtr, dlc);
        if (nb == 0) return 64'd0;
        return data & ~(64'hFFFF_FFFF_FFFF_FFFF >> (nb * 8));
    endfunction

    task automatic build(input logic [10:0] id, input logic rtr,
                         input logic ide, input logic [3:0] dlc,
                         input logic [63:0] data, input int flip);
        bit raw[$];
        int nb, run;
        bit last;
        logic [14:0] c;
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
        raw.push_back(rtr);
        raw.push_back(ide);
        raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        nb = payload_bytes(rtr, dlc);
        for (int i = 0; i < nb * 8; i++) raw.push_back(data[63 - i]);
        c = 15'd0;
        foreach (raw[i]) c = crc_step(c, raw[i]);
        if (flip >= 0) c = c ^ (15'd1 << flip);
        for (int i = 14; i >= 0; i--) raw.push_back(c[i]);
        tx = {};
        stuff_pos = {};
        raw_pos = {};
        run = 0;
        last = 1'b0;
        foreach (raw[i]) begin
            if (run == 5) begin
                stuff_pos.push_back(tx.size());
                tx.push_back(~last);
                last = ~last;
                run = 1;
            end
            raw_pos.push_back(tx.size());
            tx.push_back(raw[i]);
            if (run != 0 && raw[i] == last) run++;
            else run = 1;
            last = raw[i];
        end
        if (run == 5) begin
            stuff_pos.push_back(tx.size());
            tx.push_back(~last);
        end
        crc_end = tx.size();
        ack_idx = crc_end + 1;
        eof_idx = crc_end + 3;
        repeat (13) tx.push_back(1'b1);
    endtask

    task automatic drive_bit(input int idx, input bit b);
        @(negedge clk);
        cur_bit = idx;
        if (ack_drive) begin
            ack_cnt++;
            ack_at = idx;
        end
        rx_bus = b;
        bit_en = 1'b1;
        @(negedge clk);
        bit_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_bit(-1, 1'b1);
    endtask

    task automatic send_n(input int n);
        ack_cnt = 0;
        ack_at = -1;
        for (int i = 0; i < n; i++) drive_bit(i, tx[i]);
        rx_bus = 1'b1;
    endtask

    task automatic push_valid(input logic [10:0] id, input logic rtr,
                              input logic [3:0] dlc, input logic [63:0] data);
        exp_t e;
        e.kind = K_VALID;
        e.at   = eof_idx + 6;
        e.id   = id;
        e.rtr  = rtr;
        e.dlc  = dlc;
        e.data = exp_payload(rtr, dlc, data);
        sb.push_back(e);
    endtask

    task automatic push_err(input int kind, input int at);
        exp_t e;
        e.kind = kind;
        e.at   = at;
        e.id   = '0;
        e.rtr  = 1'b0;
        e.dlc  = '0;
        e.data = '0;
        sb.push_back(e);
    endtask

    task automatic check_frame(input string tag, input int exp_ack);
        chk({tag, "_ack_cnt"}, 64'(ack_cnt), 64'(exp_ack));
        if (exp_ack != 0) chk({tag, "_ack_pos"}, 64'(ack_at), 64'(ack_idx));
        chk({tag, "_pending"}, 64'(sb.size()), 64'd0);
        sb = {};
    endtask

    always @(negedge clk) begin
        if (rst_n && (rx_valid || stuff_err || crc_err || form_err)) begin
            mon_kind = rx_valid ? K_VALID : stuff_err ? K_STUFF :
                       crc_err ? K_CRC : K_FORM;
            chk("evt_onehot",
                64'($countones({rx_valid, stuff_err, crc_err, form_err})),
                64'd1);
            if (sb.size() == 0) begin
                chk("evt_unexpected", 64'(mon_kind), 64'd99);
            end else begin
                mon_e = sb.pop_front();
                chk("evt_kind", 64'(mon_kind), 64'(mon_e.kind));
                chk("evt_bit", 64'(cur_bit), 64'(mon_e.at));
                if (mon_e.kind == K_VALID) begin
                    chk("rx_id", 64'(rx_id), 64'(mon_e.id));
                    chk("rx_rtr", 64'(rx_rtr), 64'(mon_e.rtr));
                    chk("rx_dlc", 64'(rx_dlc), 64'(mon_e.dlc));
                    chk("rx_data", rx_data, mon_e.data);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached, run incomplete");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rx_bus  = 1'b1;
        bit_en  = 1'b0;
        rst_n   = 1'b1;
        cur_bit = -1;
        #2 rst_n = 1'b0;
        #3;
        chk("rst_id", 64'(rx_id), 64'd0);
        chk("rst_data", rx_data, 64'd0);
        chk("rst_misc", 64'({ack_drive, rx_rtr, rx_dlc, rx_valid,
                             stuff_err, crc_err, form_err}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        idle(12);
        build(11'h123, 1'b0, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, -1);
        push_valid(11'h123, 1'b0, 4'd2, 64'hABCD_0000_0000_0000);
        send_n(tx.size());
        check_frame("a", 1);

        idle(12);
        build(11'h000, 1'b0, 1'b0, 4'd0, 64'd0, -1);
        push_valid(11'h000, 1'b0, 4'd0, 64'd0);
        send_n(tx.size());
        check_frame("zero", 1);

        idle(12);
        build(11'h000, 1'b0, 1'b0, 4'd0, 64'd0, -1);
        tx[stuff_pos[0]] = ~tx[stuff_pos[0]];
        push_err(K_STUFF, stuff_pos[0]);
        send_n(tx.size());
        check_frame("stuff", 0);

        idle(12);
        build(11'h123, 1'b0, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, 3);
        while (tx.size() > crc_end + 1) void'(tx.pop_back());
        push_err(K_CRC, crc_end);
        send_n(tx.size());
        check_frame("crc", 0);
        idle(10);
        build(11'h123, 1'b0, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, -1);
        send_n(tx.size());
        check_frame("crc_ign", 0);
        idle(11);
        push_valid(11'h123, 1'b0, 4'd2, 64'hABCD_0000_0000_0000);
        send_n(tx.size());
        check_frame("crc_rec", 1);

        idle(12);
        build(11'h5A5, 1'b1, 1'b0, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, -1);
        push_valid(11'h5A5, 1'b1, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF);
        send_n(tx.size());
        check_frame("rtr", 1);

        idle(12);
        build(11'h0F0, 1'b0, 1'b0, 4'd15, 64'h0123_4567_89AB_CDEF, -1);
        push_valid(11'h0F0, 1'b0, 4'd15, 64'h0123_4567_89AB_CDEF);
        send_n(tx.size());
        check_frame("dlc15", 1);

        idle(12);
        build(11'h123, 1'b0, 1'b1, 4'd2, 64'hABCD_0000_0000_0000, -1);
        push_err(K_FORM, raw_pos[13]);
        send_n(tx.size());
        check_frame("ide", 0);

        idle(12);
        build(11'h123, 1'b0, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, -1);
        tx[eof_idx + 3] = 1'b0;
        push_err(K_FORM, eof_idx + 3);
        send_n(tx.size());
        check_frame("eof", 1);

        idle(12);
        build(11'h123, 1'b0, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, -1);
        send_n(raw_pos[24] + 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_id", 64'(rx_id), 64'd0);
        chk("midrst_data", rx_data, 64'd0);
        chk("midrst_misc", 64'({ack_drive, rx_rtr, rx_dlc}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_frame("midrst", 0);
        idle(10);
        send_n(tx.size());
        check_frame("short_ign", 0);
        idle(11);
        push_valid(11'h123, 1'b0, 4'd2, 64'hABCD_0000_0000_0000);
        send_n(tx.size());
        check_frame("post_rst", 1);

        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(11);
        build(11'h3C5, 1'b0, 1'b0, 4'd1, 64'h5A00_0000_0000_0000, -1);
        push_valid(11'h3C5, 1'b0, 4'd1, 64'h5A00_0000_0000_0000);
        send_n(tx.size());
        check_frame("idle11", 1);

        idle(4);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
